uart_tx_arb: RTL and testbench

- Shares one UART byte transmitter (start/data/busy interface) between N_REQ byte-stream requesters.
- Arbitration is round-robin and packet-locked: a granted requester keeps the transmitter until it delivers a byte flagged last, or until it stalls longer than GAP_TIMEOUT.
- Sits between on-chip message sources (echo path, status/debug reporters) and the UART transmitter.

---
 rtl/uart_tx_arb.sv | 129 ++++++++++++
 tb/tb_uart_tx_arb.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arb.sv
// uart_tx_arb: round-robin, packet-locked sharing of one UART byte
// transmitter between N_REQ byte-stream requesters. A granted requester
// keeps the transmitter until it sends a byte flagged last, or until it
// stalls for GAP_TIMEOUT cycles inside its packet.
module uart_tx_arb #(
   parameter  int N_REQ       = 4,
   parameter  int GAP_TIMEOUT = 1_000_000,
   localparam int IDW         = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [N_REQ-1:0]   req_valid,
   input  logic [8*N_REQ-1:0] req_data,
   input  logic [N_REQ-1:0]   req_last,
   output logic [N_REQ-1:0]   req_ready,
   output logic               tx_start,
   output logic [7:0]         tx_data,
   input  logic               tx_busy,
   output logic [IDW-1:0]     grant_id,
   output logic               pkt_active,
   output logic               gap_timeout
);

   localparam int CW = $clog2(GAP_TIMEOUT);

   typedef enum logic [2:0] {IDLE, SEND, WAIT_ACK, WAIT_DONE, HOLD} state_t;

   state_t                  state;
   logic [IDW-1:0]          ptr;
   logic [CW-1:0]           gap_cnt;
   logic                    last_q;

   logic [N_REQ-1:0][7:0]   data_v;
   logic [IDW-1:0]          win_idx;
   logic                    win_vld;
   logic [IDW-1:0]          sel_idx;
   logic                    acc;
   int                      scan;

   assign data_v = req_data;

   // Round-robin winner: first valid index at ptr+1, ptr+2, ... (mod N_REQ).
   // Scanning from the far end lets the nearest valid index overwrite.
   always_comb begin
      win_idx = '0;
      win_vld = 1'b0;
      scan    = 0;
      for (int k = N_REQ; k >= 1; k--) begin
         scan = int'(ptr) + k;
         if (scan >= N_REQ) scan = scan - N_REQ;
         if (req_valid[IDW'(scan)]) begin
            win_vld = 1'b1;
            win_idx = IDW'(scan);
         end
      end
   end

   // One-hot accept: open arbitration in IDLE, owner-only in HOLD, and
   // nothing while the transmitter is busy or reset is asserted.
   always_comb begin
      req_ready = '0;
      if (rst_n && !tx_busy) begin
         case (state)
            IDLE:    if (win_vld) req_ready[win_idx] = 1'b1;
            HOLD:    req_ready[grant_id] = req_valid[grant_id];
            default: req_ready = '0;
         endcase
      end
   end

   assign acc     = |req_ready;
   assign sel_idx = (state == IDLE) ? win_idx : grant_id;

   // Arbiter FSM; every output it drives is registered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         ptr         <= IDW'(N_REQ - 1);
         gap_cnt     <= '0;
         last_q      <= 1'b0;
         grant_id    <= '0;
         tx_data     <= '0;
         tx_start    <= 1'b0;
         pkt_active  <= 1'b0;
         gap_timeout <= 1'b0;
      end else begin
         tx_start    <= 1'b0;
         gap_timeout <= 1'b0;
         case (state)
            IDLE, HOLD: begin
               if (acc) begin
                  tx_data    <= data_v[sel_idx];
                  grant_id   <= sel_idx;
                  last_q     <= req_last[sel_idx];
                  pkt_active <= 1'b1;
                  tx_start   <= 1'b1;
                  state      <= SEND;
               end else if (state == HOLD) begin
                  // A valid owner byte (even if blocked by busy) defers the timeout.
                  if (!req_valid[grant_id] && gap_cnt == CW'(GAP_TIMEOUT - 1)) begin
                     gap_timeout <= 1'b1;
                     pkt_active  <= 1'b0;
                     ptr         <= grant_id;
                     state       <= IDLE;
                  end else if (gap_cnt != CW'(GAP_TIMEOUT - 1)) begin
                     gap_cnt <= gap_cnt + 1'b1;
                  end
               end
            end
            SEND:      state <= WAIT_ACK;
            WAIT_ACK:  if (tx_busy) state <= WAIT_DONE;
            WAIT_DONE: begin
               if (!tx_busy) begin
                  if (last_q) begin
                     pkt_active <= 1'b0;
                     ptr        <= grant_id;
                     state      <= IDLE;
                  end else begin
                     gap_cnt <= '0;
                     state   <= HOLD;
                  end
               end
            end
            default:   state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_arb.sv
// tb_uart_tx_arb: directed table-driven bench for uart_tx_arb (N_REQ=4,
// GAP_TIMEOUT=16) with a behavioural transmitter that raises busy the
// cycle after tx_start and holds it for busy_len cycles.
module tb_uart_tx_arb;

   localparam int N   = 4;
   localparam int GAP = 16;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [N-1:0]     req_valid = '0;
   logic [8*N-1:0]   req_data = '0;
   logic [N-1:0]     req_last = '0;
   logic [N-1:0]     req_ready;
   logic             tx_start;
   logic [7:0]       tx_data;
   logic             tx_busy = 1'b0;
   logic [1:0]       grant_id;
   logic             pkt_active;
   logic             gap_timeout;

   int n_vec = 0;
   int n_err = 0;

   uart_tx_arb #(.N_REQ(N), .GAP_TIMEOUT(GAP)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
      .req_ready(req_ready), .tx_start(tx_start), .tx_data(tx_data),
      .tx_busy(tx_busy), .grant_id(grant_id), .pkt_active(pkt_active),
      .gap_timeout(gap_timeout)
   );

   always #5 clk = ~clk;

   // Mock transmitter
   int         busy_len = 5;
   int         bcnt = 0;
   bit         start_seen = 0;
   int         n_start = 0;
   logic [7:0] txlog[$];

   always @(posedge clk) begin
      #1;
      if (!rst_n) begin
         tx_busy = 1'b0; bcnt = 0; start_seen = 0;
      end else begin
         if (start_seen) begin
            tx_busy = 1'b1; bcnt = busy_len;
         end else if (bcnt > 0) begin
            bcnt--;
            if (bcnt == 0) tx_busy = 1'b0;
         end
         start_seen = tx_start;
         if (tx_start) begin
            n_start++;
            txlog.push_back(tx_data);
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Per-cycle invariants: at most one ready bit, none while busy.
   always @(negedge clk) begin
      #2;
      if (rst_n) begin
         chk("ready_onehot", 32'($onehot0(req_ready)), 32'd1);
         if (tx_busy) chk("ready_while_busy", 32'(req_ready), 32'd0);
      end
   end

   // Called at a negedge; returns at a negedge once the byte has been accepted.
   task automatic send_byte(input int r, input logic [7:0] d, input logic l, input int tmo);
      bit got;
      got = 0;
      req_data[r*8 +: 8] = d;
      req_last[r] = l;
      req_valid[r] = 1'b1;
      for (int c = 0; c < tmo; c++) begin
         #1;
         if (req_ready[r]) begin got = 1; break; end
         @(negedge clk);
      end
      chk("accept_seen", 32'(got), 32'd1);
      @(negedge clk);
      req_valid[r] = 1'b0;
   endtask

   task automatic wait_idle(input int tmo);
      bit done;
      done = 0;
      for (int c = 0; c < tmo; c++) begin
         @(negedge clk);
         if (!pkt_active && !tx_busy) begin done = 1; break; end
      end
      chk("idle_reached", 32'(done), 32'd1);
   endtask

   task automatic wait_busy(input logic lvl, input int tmo);
      bit done;
      done = 0;
      for (int c = 0; c < tmo; c++) begin
         @(negedge clk);
         if (tx_busy === lvl) begin done = 1; break; end
      end
      chk("busy_level", 32'(done), 32'd1);
   endtask

   typedef struct {
      logic [3:0]  mask;
      logic [31:0] data;
      int          exp_id;
      logic [7:0]  exp_data;
   } vec_t;

   vec_t tbl[10];

   initial begin
      logic [3:0] exp_oh;
      bit         got;
      bit         bad;
      int         n0;

      // Pointer history in comments: ptr starts at 3 and follows each grant.
      tbl[0] = '{4'b0001, 32'h0000_0055, 0, 8'h55};
      tbl[1] = '{4'b1111, 32'hA3A2_A1A0, 1, 8'hA1};
      tbl[2] = '{4'b1111, 32'hA3A2_A1A0, 2, 8'hA2};
      tbl[3] = '{4'b1111, 32'hA3A2_A1A0, 3, 8'hA3};
      tbl[4] = '{4'b1111, 32'hA3A2_A1A0, 0, 8'hA0};
      tbl[5] = '{4'b0101, 32'hA3A2_A1A0, 2, 8'hA2};
      tbl[6] = '{4'b0101, 32'hA3A2_A1A0, 0, 8'hA0};
      tbl[7] = '{4'b1000, 32'hA3A2_A1A0, 3, 8'hA3};
      tbl[8] = '{4'b0110, 32'hA3A2_A1A0, 1, 8'hA1};
      tbl[9] = '{4'b0011, 32'hA3A2_A1A0, 0, 8'hA0};

      // Reset state, with requests present to show ready stays low.
      req_valid = 4'b1111;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_outputs", {req_ready, tx_start, tx_data, grant_id, pkt_active, gap_timeout}, 32'd0);
      req_valid = '0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Single-byte packets through the round-robin table.
      for (int v = 0; v < 10; v++) begin
         req_data  = tbl[v].data;
         req_last  = '1;
         req_valid = tbl[v].mask;
         got = 0;
         for (int c = 0; c < 50; c++) begin
            #1;
            if (|req_ready) begin got = 1; break; end
            @(negedge clk);
         end
         exp_oh = '0;
         exp_oh[tbl[v].exp_id] = 1'b1;
         chk("vec_ready", 32'(req_ready), 32'(exp_oh));
         @(negedge clk);
         req_valid = '0;
         chk("vec_tx_start", 32'(tx_start), 32'd1);
         chk("vec_tx_data", 32'(tx_data), 32'(tbl[v].exp_data));
         chk("vec_grant_id", 32'(grant_id), 32'(tbl[v].exp_id));
         chk("vec_pkt_active", 32'(pkt_active), 32'd1);
         wait_idle(50);
      end

      // Packet lock: req1 three bytes, req2 pending the whole time (ptr=0).
      txlog.delete();
      req_data[2*8 +: 8] = 8'hB2;
      req_last[2] = 1'b1;
      req_valid[2] = 1'b1;
      send_byte(1, 8'h11, 1'b0, 50);
      send_byte(1, 8'h22, 1'b0, 50);
      send_byte(1, 8'h33, 1'b1, 50);
      send_byte(2, 8'hB2, 1'b1, 50);
      wait_idle(50);
      chk("lock_count", 32'(txlog.size()), 32'd4);
      if (txlog.size() == 4) begin
         chk("lock_b0", 32'(txlog[0]), 32'h11);
         chk("lock_b1", 32'(txlog[1]), 32'h22);
         chk("lock_b2", 32'(txlog[2]), 32'h33);
         chk("lock_b3", 32'(txlog[3]), 32'hB2);
      end

      // Gap timeout: req3 stalls after a non-last byte while req0 waits (ptr=2).
      req_data[0 +: 8] = 8'hD0;
      req_last[0] = 1'b1;
      req_valid[0] = 1'b1;
      send_byte(3, 8'hC3, 1'b0, 50);
      wait_busy(1'b1, 20);
      wait_busy(1'b0, 20);
      // k=0 is the first cycle with busy low; HOLD then idles 16 cycles
      // (k=1..16) and the registered pulse and the new grant show at k=17.
      for (int k = 1; k <= 17; k++) begin
         @(negedge clk);
         #1;
         chk("gap_pulse", 32'(gap_timeout), 32'(k == 17));
         chk("gap_ready0", 32'(req_ready), (k == 17) ? 32'd1 : 32'd0);
         chk("gap_pkt_active", 32'(pkt_active), 32'(k != 17));
      end
      @(negedge clk);
      req_valid[0] = 1'b0;
      chk("gap_pulse_end", 32'(gap_timeout), 32'd0);
      chk("gap_next_data", 32'(tx_data), 32'hD0);
      chk("gap_next_grant", 32'(grant_id), 32'd0);
      wait_idle(50);

      // Long busy: second byte held off for the whole busy window (ptr=0).
      busy_len = 100;
      send_byte(1, 8'hE1, 1'b0, 50);
      n0 = n_start;
      req_data[8 +: 8] = 8'hE2;
      req_last[1] = 1'b1;
      req_valid[1] = 1'b1;
      wait_busy(1'b1, 20);
      bad = 0;
      got = 0;
      for (int c = 0; c < 300; c++) begin
         @(negedge clk);
         #1;
         if (!tx_busy) begin got = 1; break; end
         if (req_ready != 0 || tx_start) bad = 1;
      end
      chk("busy_fell", 32'(got), 32'd1);
      chk("busy_no_accept", 32'(bad), 32'd0);
      chk("busy_one_start", 32'(n_start), 32'(n0));
      chk("busy_ready_k0", 32'(req_ready), 32'd0);
      @(negedge clk);
      #1;
      chk("busy_ready_k1", 32'(req_ready), 32'd2);
      @(negedge clk);
      req_valid[1] = 1'b0;
      busy_len = 5;
      chk("busy_second_data", 32'(tx_data), 32'hE2);
      #2;
      chk("busy_two_starts", 32'(n_start), 32'(n0 + 1));
      wait_idle(300);

      // Reset while in WAIT_DONE mid-packet, then priority restarts at req0.
      busy_len = 20;
      send_byte(2, 8'hF2, 1'b0, 50);
      wait_busy(1'b1, 20);
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrst_outputs", {req_ready, tx_start, tx_data, grant_id, pkt_active, gap_timeout}, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      busy_len = 5;
      req_data  = 32'h0002_0001;
      req_last  = 4'b0101;
      req_valid = 4'b0101;
      #1;
      chk("midrst_ready", 32'(req_ready), 32'd1);
      @(negedge clk);
      req_valid = '0;
      chk("midrst_data", 32'(tx_data), 32'h01);
      chk("midrst_grant", 32'(grant_id), 32'd0);
      wait_idle(50);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

endmodule
